time_keeper: RTL

TIME_KEEPER -- requirements
Module: time_keeper

---
 rtl/clock_pkg.sv | 35 +++
 rtl/tick_gen.sv | 33 +++
 rtl/time_keeper.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared types and constants for the time-of-day clock.
//   bcd_t        : one BCD digit (always 0..9 in use)
//   time_t       : full displayed time, BCD digits plus 12-hour pm flag
//   *_MAX        : last value of each digit / hour field before it rolls over
//   RST_TIME_*   : time shown after reset for each display mode
package clock_pkg;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t hr_t;
        bcd_t hr_u;
        bcd_t mn_t;
        bcd_t mn_u;
        bcd_t sc_t;
        bcd_t sc_u;
        logic pm;
    } time_t;

    // Digit limits: tens of minutes/seconds stop at 5, any units digit at 9.
    localparam bcd_t       TENS_MAX  = 4'd5;
    localparam bcd_t       UNITS_MAX = 4'd9;
    // Hour limits as packed BCD pairs {tens, units}.
    localparam logic [7:0] HR24_MAX  = 8'h23;
    localparam logic [7:0] HR12_MAX  = 8'h12;

    // Binary bounds used to validate a load request.
    localparam logic [4:0] SET_HR24_MAX = 5'd23;
    localparam logic [4:0] SET_HR12_MAX = 5'd12;
    localparam logic [5:0] SET_MIN_MAX  = 6'd59;

    localparam time_t RST_TIME_12H = time_t'({4'd1, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0});
    localparam time_t RST_TIME_24H = time_t'('0);

endpackage

// File: rtl/tick_gen.sv
// Prescaler: divides clk down to one tick every TICK_DIV cycles.
//   clk  : clock
//   rst  : synchronous active-high reset, count -> 0
//   en   : count enable; count holds while low
//   clr  : synchronous clear of the count (used when the time is loaded)
//   tick : high during the cycle in which the count wraps back to 0
module tick_gen #(
    parameter int TICK_DIV = 100000000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (en)
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end

    // Combinational so the time registers advance on the same edge the
    // count wraps.
    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/time_keeper.sv
// Time-of-day clock with BCD outputs, 12h/24h display and time load.
//   clk, rst               : clock, synchronous active-high reset
//   run                    : 1 = advance on prescaler ticks, 0 = freeze
//   set_valid/hour/min/pm  : load request (binary hour/minute)
//   set_ack / set_err      : one-cycle result pulse, a cycle after the request
//   hr_*, mn_*, sc_*       : BCD digits (t = tens, u = units)
//   pm                     : pm flag (12h mode only, else 0)
//   sec_pulse / hour_pulse : one-cycle pulses on second advance / hour rollover
module time_keeper
    import clock_pkg::*;
#(
    parameter int SYS_FREQ = 100000000,
    parameter int TICK_DIV = SYS_FREQ,
    parameter int MODE_24H = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       set_valid,
    input  logic [4:0] set_hour,
    input  logic [5:0] set_min,
    input  logic       set_pm,
    output logic       set_ack,
    output logic       set_err,
    output logic [3:0] hr_t,
    output logic [3:0] hr_u,
    output logic [3:0] mn_t,
    output logic [3:0] mn_u,
    output logic [3:0] sc_t,
    output logic [3:0] sc_u,
    output logic       pm,
    output logic       sec_pulse,
    output logic       hour_pulse
);

    localparam bit    IS_24H   = (MODE_24H != 0);
    localparam time_t RST_TIME = IS_24H ? RST_TIME_24H : RST_TIME_12H;

    // Binary (0..63) to two BCD digits by repeated subtraction of ten.
    function automatic logic [7:0] bin2bcd(input logic [5:0] v);
        logic [5:0] r;
        logic [3:0] t;
        r = v;
        t = 4'd0;
        for (int i = 0; i < 6; i++) begin
            if (r >= 6'd10) begin
                r = r - 6'd10;
                t = t + 4'd1;
            end
        end
        return {t, 4'(r)};
    endfunction

    time_t cur, nxt, ld_time;
    logic  tick, set_ok, load, min_wrap;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (run),
        .clr  (load),
        .tick (tick)
    );

    always_comb begin
        if (IS_24H)
            set_ok = (set_hour <= SET_HR24_MAX);
        else
            set_ok = (set_hour != 5'd0) && (set_hour <= SET_HR12_MAX);
        set_ok = set_ok && (set_min <= SET_MIN_MAX);
        load   = set_valid && set_ok;
    end

    always_comb begin
        ld_time               = '0;
        {ld_time.hr_t, ld_time.hr_u} = bin2bcd({1'b0, set_hour});
        {ld_time.mn_t, ld_time.mn_u} = bin2bcd(set_min);
        ld_time.pm            = IS_24H ? 1'b0 : set_pm;
    end

    // Next time after one second; each field carries into the next only
    // when it rolls over.
    always_comb begin
        nxt      = cur;
        min_wrap = 1'b0;
        if (cur.sc_u != UNITS_MAX) begin
            nxt.sc_u = cur.sc_u + 4'd1;
        end else begin
            nxt.sc_u = 4'd0;
            if (cur.sc_t != TENS_MAX) begin
                nxt.sc_t = cur.sc_t + 4'd1;
            end else begin
                nxt.sc_t = 4'd0;
                if (cur.mn_u != UNITS_MAX) begin
                    nxt.mn_u = cur.mn_u + 4'd1;
                end else begin
                    nxt.mn_u = 4'd0;
                    if (cur.mn_t != TENS_MAX) begin
                        nxt.mn_t = cur.mn_t + 4'd1;
                    end else begin
                        nxt.mn_t = 4'd0;
                        min_wrap = 1'b1;
                        if (IS_24H && {cur.hr_t, cur.hr_u} == HR24_MAX) begin
                            {nxt.hr_t, nxt.hr_u} = 8'h00;
                        end else if (!IS_24H && {cur.hr_t, cur.hr_u} == HR12_MAX) begin
                            {nxt.hr_t, nxt.hr_u} = 8'h01;
                        end else if (!IS_24H && {cur.hr_t, cur.hr_u} == 8'h11) begin
                            // 11 -> 12 is where am/pm flips.
                            {nxt.hr_t, nxt.hr_u} = HR12_MAX;
                            nxt.pm = ~cur.pm;
                        end else if (cur.hr_u == UNITS_MAX) begin
                            nxt.hr_t = cur.hr_t + 4'd1;
                            nxt.hr_u = 4'd0;
                        end else begin
                            nxt.hr_u = cur.hr_u + 4'd1;
                        end
                    end
                end
            end
        end
    end

    // A load on a tick cycle swallows the tick, including its pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur        <= RST_TIME;
            set_ack    <= 1'b0;
            set_err    <= 1'b0;
            sec_pulse  <= 1'b0;
            hour_pulse <= 1'b0;
        end else begin
            set_ack    <= load;
            set_err    <= set_valid && !set_ok;
            sec_pulse  <= tick && !load;
            hour_pulse <= tick && !load && min_wrap;
            if (load)
                cur <= ld_time;
            else if (tick)
                cur <= nxt;
        end
    end

    assign hr_t = cur.hr_t;
    assign hr_u = cur.hr_u;
    assign mn_t = cur.mn_t;
    assign mn_u = cur.mn_u;
    assign sc_t = cur.sc_t;
    assign sc_u = cur.sc_u;
    assign pm   = IS_24H ? 1'b0 : cur.pm;

endmodule
